// File: rtl/qch_sched_pkg.sv
// Purpose: shared types, sizes and helpers for the Qch egress scheduler.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package qch_sched_pkg;

   localparam int NQ = 8;
   localparam int DW = 64;
   localparam int KW = DW / 8;
   localparam int LW = 11;

   // Queues that alternate with the Qch odd/even cycle.
   localparam int QCH_Q_EVEN = 0;
   localparam int QCH_Q_ODD  = 1;

   typedef enum logic {
      IDLE = 1'b0,
      XFER = 1'b1
   } state_t;

   // Number of 8-byte bus words needed for a frame of len bytes.
   function automatic logic [11:0] words_of(input logic [LW-1:0] len);
      logic [11:0] w_sum;
      w_sum = {1'b0, len} + 12'd7;
      return {3'b000, w_sum[11:3]};
   endfunction

endpackage

// File: rtl/qch_phase_timer.sv
// Purpose: Qch phase timer; counts 0..CYCLE_TIME-1, then toggles the phase.
// Latency: phase toggles on the clock after the count reaches CYCLE_TIME-1.
// Backpressure: none; free-running.
module qch_phase_timer
   import qch_sched_pkg::*;
#(
   parameter logic [15:0] CYCLE_TIME = 16'd1000
) (
   input  logic        i_clk,
   input  logic        i_rst_n,
   output logic        o_phase,
   output logic [15:0] o_remaining
);

   logic [15:0] r_count;
   logic        r_phase;
   logic        w_wrap;

   assign w_wrap      = (r_count == CYCLE_TIME - 16'd1);
   assign o_phase     = r_phase;
   assign o_remaining = CYCLE_TIME - 16'd1 - r_count;

   // Advance the count; at the end of a phase wrap to zero and flip the phase.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_count <= '0;
         r_phase <= 1'b0;
      end else if (w_wrap) begin
         r_count <= '0;
         r_phase <= ~r_phase;
      end else begin
         r_count <= r_count + 16'd1;
      end
   end

endmodule

// File: rtl/qch_egress_sched.sv
// Purpose: strict-priority frame selector over 8 queues, with Qch gating of queues 0/1 (stats: QCH_EGRESS_STATS_EN).
// Latency: first beat 1 cycle after eligibility; 1 idle cycle between back-to-back frames.
// Backpressure: tx_axis_tready passes straight to the selected queue's q_tready; no buffering.
module qch_egress_sched
   import qch_sched_pkg::*;
#(
   parameter logic [15:0] CYCLE_TIME = 16'd1000
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              enable_Qch,
   input  logic [7:0]        gate_mask,
   input  logic [NQ*DW-1:0]  q_tdata,
   input  logic [NQ*KW-1:0]  q_tkeep,
   input  logic [NQ-1:0]     q_tlast,
   input  logic [NQ-1:0]     q_tvalid,
   output logic [NQ-1:0]     q_tready,
   input  logic [NQ*LW-1:0]  q_frame_len,
   output logic [DW-1:0]     tx_axis_tdata,
   output logic [KW-1:0]     tx_axis_tkeep,
   output logic              tx_axis_tlast,
   output logic              tx_axis_tvalid,
   input  logic              tx_axis_tready,
   output logic [LW-1:0]     tx_frame_len,
   output logic [2:0]        tx_queue_id,
   output logic              qch_phase
`ifdef QCH_EGRESS_STATS_EN
   ,
   output logic [NQ*16-1:0]  tx_frame_cnt,
   output logic [15:0]       guard_block_cnt
`endif
);

   state_t        r_state;
   state_t        w_state_nxt;
   logic [2:0]    r_qid;
   logic [LW-1:0] r_len;
   logic          w_phase;
   logic [15:0]   w_remaining;
   logic [NQ-1:0] w_eg;
   logic [NQ-1:0] w_fit;
   logic [NQ-1:0] w_elig;
   logic          w_any;
   logic [2:0]    w_pick;
   logic          w_load;
   logic          w_done;

   qch_phase_timer #(
      .CYCLE_TIME (CYCLE_TIME)
   ) u_timer (
      .i_clk       (clk),
      .i_rst_n     (rst_n),
      .o_phase     (w_phase),
      .o_remaining (w_remaining)
   );

   assign qch_phase    = w_phase;
   assign tx_frame_len = r_len;
   assign tx_queue_id  = r_qid;

   // A frame ends on the tlast handshake of the selected queue.
   assign w_done = (r_state == XFER) & q_tvalid[r_qid] & tx_axis_tready & q_tlast[r_qid];

   // Effective gates and guard band: queues 0/1 must finish inside the current phase.
   always_comb begin
      w_eg             = gate_mask;
      w_eg[QCH_Q_EVEN] = gate_mask[QCH_Q_EVEN] & (~enable_Qch | ~w_phase);
      w_eg[QCH_Q_ODD]  = gate_mask[QCH_Q_ODD]  & (~enable_Qch |  w_phase);
      w_fit            = '1;
      for (int i = 0; i < NQ; i++) begin
         if (enable_Qch && (i == QCH_Q_EVEN || i == QCH_Q_ODD)) begin
            w_fit[i] = ({4'd0, words_of(q_frame_len[i*LW +: LW])} <= w_remaining);
         end
      end
      w_elig = q_tvalid & w_eg & w_fit;
   end

   // Strict priority: the highest-index eligible queue wins.
   always_comb begin
      w_any  = |w_elig;
      w_pick = '0;
      for (int i = 0; i < NQ; i++) begin
         if (w_elig[i]) begin
            w_pick = 3'(i);
         end
      end
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next state and the combinational pass-through of the selected queue.
   always_comb begin
      w_state_nxt    = r_state;
      w_load         = 1'b0;
      q_tready       = '0;
      tx_axis_tvalid = 1'b0;
      tx_axis_tdata  = '0;
      tx_axis_tkeep  = '0;
      tx_axis_tlast  = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_any) begin
               w_state_nxt = XFER;
               w_load      = 1'b1;
            end
         end
         XFER: begin
            tx_axis_tdata   = q_tdata[int'(r_qid)*DW +: DW];
            tx_axis_tkeep   = q_tkeep[int'(r_qid)*KW +: KW];
            tx_axis_tlast   = q_tlast[r_qid];
            tx_axis_tvalid  = q_tvalid[r_qid];
            q_tready[r_qid] = tx_axis_tready;
            if (w_done) begin
               w_state_nxt = IDLE;
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   // Latch the winner and its length; both hold until the next selection.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_qid <= '0;
         r_len <= '0;
      end else if (w_load) begin
         r_qid <= w_pick;
         r_len <= q_frame_len[int'(w_pick)*LW +: LW];
      end
   end

`ifdef QCH_EGRESS_STATS_EN
   logic [15:0] r_frame_cnt [NQ];
   logic [15:0] r_guard_cnt;
   logic        w_guard_hit;

   // Valid and open, yet held back purely because the frame would overrun the phase.
   assign w_guard_hit     = (r_state == IDLE) & (|(q_tvalid & w_eg & ~w_fit));
   assign guard_block_cnt = r_guard_cnt;

   // Per-queue completed-frame counters and the guard-band block counter, wrapping at 16 bits.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NQ; i++) begin
            r_frame_cnt[i] <= '0;
         end
         r_guard_cnt <= '0;
      end else begin
         for (int i = 0; i < NQ; i++) begin
            if (w_done && (r_qid == 3'(i))) begin
               r_frame_cnt[i] <= r_frame_cnt[i] + 16'd1;
            end
         end
         if (w_guard_hit) begin
            r_guard_cnt <= r_guard_cnt + 16'd1;
         end
      end
   end

   // Flatten the counters onto the output bus, queue i at bits [i*16 +: 16].
   always_comb begin
      tx_frame_cnt = '0;
      for (int i = 0; i < NQ; i++) begin
         tx_frame_cnt[i*16 +: 16] = r_frame_cnt[i];
      end
   end
`endif

endmodule

// File: tb/tb_qch_egress_sched.sv
// Purpose: self-checking bench for qch_egress_sched against a frame-level reference model.
// Latency: model predicts outputs every cycle; literal checks pin ordering, gaps and phase timing.
// Backpressure: tready driven constant, toggling or random; upstream valid gaps optional.
module tb_qch_egress_sched;
   import qch_sched_pkg::*;

   localparam int CT = 100;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              enable_Qch = 1'b0;
   logic [7:0]        gate_mask = 8'hFF;
   logic [NQ*DW-1:0]  q_tdata = '0;
   logic [NQ*KW-1:0]  q_tkeep = '0;
   logic [NQ-1:0]     q_tlast = '0;
   logic [NQ-1:0]     q_tvalid = '0;
   logic [NQ-1:0]     q_tready;
   logic [NQ*LW-1:0]  q_frame_len = '0;
   logic [DW-1:0]     tx_axis_tdata;
   logic [KW-1:0]     tx_axis_tkeep;
   logic              tx_axis_tlast;
   logic              tx_axis_tvalid;
   logic              tx_axis_tready = 1'b0;
   logic [LW-1:0]     tx_frame_len;
   logic [2:0]        tx_queue_id;
   logic              qch_phase;

   always #5 clk = ~clk;

   qch_egress_sched #(.CYCLE_TIME(16'(CT))) dut (
      .clk(clk), .rst_n(rst_n), .enable_Qch(enable_Qch), .gate_mask(gate_mask),
      .q_tdata(q_tdata), .q_tkeep(q_tkeep), .q_tlast(q_tlast), .q_tvalid(q_tvalid),
      .q_tready(q_tready), .q_frame_len(q_frame_len),
      .tx_axis_tdata(tx_axis_tdata), .tx_axis_tkeep(tx_axis_tkeep), .tx_axis_tlast(tx_axis_tlast),
      .tx_axis_tvalid(tx_axis_tvalid), .tx_axis_tready(tx_axis_tready),
      .tx_frame_len(tx_frame_len), .tx_queue_id(tx_queue_id), .qch_phase(qch_phase)
   );

   int n_chk = 0;
   int n_err = 0;

   // Source queues: frame lengths and serials, plus the head beat index per queue.
   int fr_len [NQ][$];
   int fr_ser [NQ][$];
   int hb [NQ];
   int ser_cnt = 0;
   bit gap_en = 0;
   int rdy_mode = 0;
   bit drv_rdy = 0;
   bit [NQ-1:0] drv_vld = '0;

   // Reference model state.
   bit         m_busy = 0;
   int         m_sel = 0;
   logic [10:0] m_len = '0;
   logic [2:0] m_id = '0;
   int         m_cyc = 0;
   bit         n_busy;
   int         n_sel;
   logic [10:0] n_len;
   logic [2:0] n_id;
   int         n_pop;
   int         cyc = 0;
   bit         chk_en = 0;
   bit         ph_chk = 0;
   int         ph_bad = 0;

   int done_id[$];
   int done_beats[$];
   int last_cyc[$];
   int first_cyc[$];
   int first_cnt[$];
   int first_ph[$];

   function automatic int beats_of(input int len);
      int b;
      b = (len + 7) / 8;
      return (b < 1) ? 1 : b;
   endfunction

   function automatic logic [63:0] beat_dat(input int q, input int ser, input int b);
      return {8'(q), 24'(ser), 32'(b)};
   endfunction

   function automatic logic [7:0] keep_of(input int len, input int b);
      logic [7:0] k;
      int r;
      if (b < beats_of(len) - 1) return 8'hFF;
      r = len - 8 * b;
      k = '0;
      for (int j = 0; j < 8; j++) if (j < r) k[j] = 1'b1;
      return k;
   endfunction

   function automatic bit all_empty();
      for (int i = 0; i < NQ; i++) if (fr_len[i].size() > 0) return 0;
      return 1;
   endfunction

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         if (n_err < 40) $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   task automatic push(input int q, input int len);
      fr_len[q].push_back(len);
      fr_ser[q].push_back(ser_cnt);
      ser_cnt++;
   endtask

   task automatic drive_inputs();
      logic [NQ*DW-1:0] d;
      logic [NQ*KW-1:0] k;
      logic [NQ-1:0]    l;
      logic [NQ-1:0]    v;
      logic [NQ*LW-1:0] f;
      d = '0; k = '0; l = '0; v = '0; f = '0;
      for (int i = 0; i < NQ; i++) begin
         if (fr_len[i].size() > 0) begin
            int len;
            len = fr_len[i][0];
            d[i*DW +: DW] = beat_dat(i, fr_ser[i][0], hb[i]);
            k[i*KW +: KW] = keep_of(len, hb[i]);
            l[i] = (hb[i] == beats_of(len) - 1);
            v[i] = !(gap_en && ($urandom_range(0, 3) == 0));
            f[i*LW +: LW] = 11'(len);
         end
      end
      drv_vld = v;
      q_tdata = d; q_tkeep = k; q_tlast = l; q_tvalid = v; q_frame_len = f;
      case (rdy_mode)
         0: drv_rdy = 1'b1;
         1: drv_rdy = ~drv_rdy;
         default: drv_rdy = 1'($urandom_range(0, 1));
      endcase
      tx_axis_tready = drv_rdy;
   endtask

   // Frame-level rules: pick among open, valid, fitting queues; advance on handshakes.
   task automatic compute_next();
      int cnt, rem, ph, len;
      bit found, open, fit;
      n_busy = m_busy; n_sel = m_sel; n_len = m_len; n_id = m_id; n_pop = -1;
      if (!rst_n) return;
      cnt = m_cyc % CT;
      rem = CT - 1 - cnt;
      ph = (m_cyc / CT) % 2;
      found = 0;
      if (!m_busy) begin
         for (int i = NQ - 1; i >= 0; i--) begin
            open = gate_mask[i];
            if (enable_Qch && i == 0 && ph == 1) open = 0;
            if (enable_Qch && i == 1 && ph == 0) open = 0;
            fit = 1;
            if (enable_Qch && i < 2 && drv_vld[i]) fit = ((fr_len[i][0] + 7) / 8 <= rem);
            if (!found && drv_vld[i] && open && fit) begin
               found = 1; n_busy = 1; n_sel = i;
               n_len = 11'(fr_len[i][0]); n_id = 3'(i);
            end
         end
      end else if (drv_vld[m_sel] && drv_rdy) begin
         len = fr_len[m_sel][0];
         if (hb[m_sel] == 0) begin
            first_cyc.push_back(cyc); first_cnt.push_back(cnt); first_ph.push_back(ph);
         end
         if (ph_chk && m_sel < 2 && ph != m_sel) ph_bad++;
         n_pop = m_sel;
         if (hb[m_sel] == beats_of(len) - 1) begin
            n_busy = 0;
            done_id.push_back(m_sel);
            done_beats.push_back(hb[m_sel] + 1);
            last_cyc.push_back(cyc);
         end
      end
   endtask

   task automatic apply_next();
      m_busy = n_busy; m_sel = n_sel; m_len = n_len; m_id = n_id;
      if (n_pop >= 0) begin
         hb[n_pop]++;
         if (hb[n_pop] == beats_of(fr_len[n_pop][0])) begin
            void'(fr_len[n_pop].pop_front());
            void'(fr_ser[n_pop].pop_front());
            hb[n_pop] = 0;
         end
      end
      if (rst_n) m_cyc++;
      cyc++;
   endtask

   task automatic tick();
      @(negedge clk); #1;
      compute_next();
      @(posedge clk); #1;
      apply_next();
      drive_inputs();
   endtask

   task automatic drain(input string nm, input int budget);
      int k;
      k = 0;
      while ((!all_empty() || m_busy) && k < budget) begin
         tick();
         k++;
      end
      chk(nm, 64'(all_empty() && !m_busy), 64'd1);
   endtask

   // Per-cycle comparison of every DUT output against the model.
   task automatic compare_loop();
      logic       ev;
      logic [7:0] er;
      forever begin
         @(negedge clk);
         if (chk_en) begin
            ev = 1'b0;
            er = '0;
            if (m_busy) begin
               ev = drv_vld[m_sel];
               er = 8'(drv_rdy) << m_sel;
            end
            chk("tx_tvalid", 64'(tx_axis_tvalid), 64'(ev));
            chk("q_tready", 64'(q_tready), 64'(er));
            if (ev) begin
               chk("tx_tdata", tx_axis_tdata, beat_dat(m_sel, fr_ser[m_sel][0], hb[m_sel]));
               chk("tx_tkeep", 64'(tx_axis_tkeep), 64'(keep_of(fr_len[m_sel][0], hb[m_sel])));
               chk("tx_tlast", 64'(tx_axis_tlast), 64'(hb[m_sel] == beats_of(fr_len[m_sel][0]) - 1));
            end
            chk("tx_frame_len", 64'(tx_frame_len), 64'(m_len));
            chk("tx_queue_id", 64'(tx_queue_id), 64'(m_id));
            chk("qch_phase", 64'(qch_phase), 64'((m_cyc / CT) % 2));
         end
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, errors=%0d", n_err);
      $fatal(1, "watchdog");
   end

   initial begin
      int b, p_cyc, nd;
      for (int i = 0; i < NQ; i++) hb[i] = 0;
      fork
         compare_loop();
      join_none
      drive_inputs();
      #12;
      chk("rst_tvalid", 64'(tx_axis_tvalid), 64'd0);
      chk("rst_q_tready", 64'(q_tready), 64'd0);
      chk("rst_len", 64'(tx_frame_len), 64'd0);
      chk("rst_qid", 64'(tx_queue_id), 64'd0);
      chk("rst_phase", 64'(qch_phase), 64'd0);
      chk("rst_tlast", 64'(tx_axis_tlast), 64'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      chk_en = 1;

      // Strict priority with 1 idle cycle between frames.
      enable_Qch = 0; gate_mask = 8'hFF; rdy_mode = 0;
      tick();
      b = done_id.size();
      push(3, 64); push(6, 64);
      drive_inputs();
      p_cyc = cyc;
      drain("A", 100);
      chk("A_first_id", 64'(done_id[b]), 64'd6);
      chk("A_second_id", 64'(done_id[b+1]), 64'd3);
      chk("A_beats0", 64'(done_beats[b]), 64'd8);
      chk("A_beats1", 64'(done_beats[b+1]), 64'd8);
      chk("A_latency", 64'(first_cyc[b] - p_cyc), 64'd1);
      chk("A_gap", 64'(first_cyc[b+1] - last_cyc[b]), 64'd2);

      // tready toggling every cycle.
      rdy_mode = 1;
      b = done_id.size();
      push(4, 64);
      drain("D", 100);
      chk("D_id", 64'(done_id[b]), 64'd4);
      chk("D_beats", 64'(done_beats[b]), 64'd8);
      rdy_mode = 0;

      // Qch alternation of queues 0 and 1.
      enable_Qch = 1; ph_chk = 1;
      b = done_id.size();
      for (int i = 0; i < 4; i++) begin
         push(0, $urandom_range(16, 64));
         push(1, $urandom_range(16, 64));
      end
      drain("B", 2000);
      chk("B_frames", 64'(done_id.size() - b), 64'd8);
      chk("B_phase_ok", 64'(ph_bad), 64'd0);
      ph_chk = 0;

      // Guard band: 188 words never fits a 100-cycle phase; 99 words fits only at count 0.
      b = done_id.size();
      push(0, 1500);
      for (int i = 0; i < 250; i++) tick();
      chk("C_blocked", 64'(done_id.size() - b), 64'd0);
      chk("C_untouched", 64'(hb[0]), 64'd0);
      fr_len[0].delete(); fr_ser[0].delete();
      drive_inputs();
      b = first_cnt.size();
      push(0, 792);
      drive_inputs();
      drain("C", 600);
      chk("C_start_count", 64'(first_cnt[b]), 64'd1);
      chk("C_start_phase", 64'(first_ph[b]), 64'd0);
      chk("C_beats", 64'(done_beats[done_beats.size()-1]), 64'd99);
      enable_Qch = 0;

      // Gate closing mid-frame does not abort it, and blocks reselection.
      gate_mask = 8'hFF;
      push(5, 64); push(5, 64);
      drive_inputs();
      for (int i = 0; i < 100; i++) begin
         tick();
         if (m_busy && m_sel == 5 && hb[5] == 3) break;
      end
      gate_mask[5] = 1'b0;
      nd = done_id.size();
      for (int i = 0; i < 50 && done_id.size() == nd; i++) tick();
      chk("E_done_id", 64'(done_id[done_id.size()-1]), 64'd5);
      chk("E_done_beats", 64'(done_beats[done_beats.size()-1]), 64'd8);
      for (int i = 0; i < 30; i++) tick();
      chk("E_held", 64'(fr_len[5].size()), 64'd1);
      chk("E_idle", 64'(m_busy), 64'd0);
      gate_mask = 8'hFF;
      drain("E", 100);

      // Randomized traffic: random gates, Qch, backpressure and valid gaps.
      for (int r = 0; r < 4; r++) begin
         enable_Qch = 1'($urandom_range(0, 1));
         gate_mask = 8'($urandom_range(0, 255));
         gap_en = 1; rdy_mode = 2;
         for (int i = 0; i < 12; i++) push($urandom_range(0, 7), $urandom_range(1, 160));
         for (int i = 0; i < 300; i++) tick();
         gate_mask = 8'hFF; gap_en = 0; rdy_mode = 0;
         drain("F", 3000);
      end
      enable_Qch = 0;

      // Asynchronous reset mid-frame.
      push(2, 64);
      drive_inputs();
      for (int i = 0; i < 50; i++) begin
         tick();
         if (m_busy && m_sel == 2 && hb[2] == 4) break;
      end
      @(negedge clk); #2;
      rst_n = 1'b0;
      #1;
      chk("G_tvalid", 64'(tx_axis_tvalid), 64'd0);
      chk("G_q_tready", 64'(q_tready), 64'd0);
      m_busy = 0; m_len = '0; m_id = '0; m_cyc = 0;
      if (fr_len[2].size() > 0) begin
         void'(fr_len[2].pop_front());
         void'(fr_ser[2].pop_front());
      end
      hb[2] = 0;
      drive_inputs();
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         drive_inputs();
         cyc++;
      end
      rst_n = 1'b1;
      #1;
      chk("G_phase", 64'(qch_phase), 64'd0);
      chk("G_qid", 64'(tx_queue_id), 64'd0);
      b = done_id.size();
      push(2, 24);
      drive_inputs();
      drain("G", 100);
      chk("G_after_id", 64'(done_id[b]), 64'd2);
      chk("G_after_beats", 64'(done_beats[b]), 64'd3);

      chk_en = 0;
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
